// File: rtl/freq_vote_controller.sv
// freq_vote_controller
//   Sequences a frequency detector (start pulse, wait for its answer with a
//   timeout, rest for a fixed gap) and only reports a class once VOTES
//   consecutive measurements agree on it.
//
// Parameters
//   VOTES    consecutive agreeing samples needed for a report (2..7)
//   TIMEOUT  cycles spent in WAIT before a measurement is abandoned
//   GAP      idle cycles between the end of one measurement and the next
//
// Ports
//   clock        rising-edge clock
//   reset        synchronous, active-high reset
//   enable       level; 1 = keep measuring
//   measAnswer   detector class (0 none, 1..4 valid tones, 5..7 invalid)
//   measDone     detector pulse; measAnswer valid in the same cycle
//   measStart    one-cycle pulse launching a detector measurement
//   finalAnswer  last reported class, held between reports
//   finalDone    one-cycle pulse; finalAnswer valid in the same cycle
//   busy         high whenever the controller is not idle
//   timeoutFlag  one-cycle pulse when a measurement timed out
module freq_vote_controller #(
  parameter int VOTES   = 3,
  parameter int TIMEOUT = 100000,
  parameter int GAP     = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] measAnswer,
  input  logic       measDone,
  output logic       measStart,
  output logic [2:0] finalAnswer,
  output logic       finalDone,
  output logic       busy,
  output logic       timeoutFlag
);

  // Counters only ever reach PARAM-1, so clog2(PARAM) bits never wrap.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP - 1);
  localparam logic [2:0]    VOTES_FULL = 3'(VOTES);
  localparam logic [2:0]    VOTES_PREV = 3'(VOTES - 1);
  // 7 can never be a captured sample (invalid classes fold to 5), so the
  // first sample of a session always starts a fresh run.
  localparam logic [2:0]    NO_SAMPLE  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_EVAL,
    S_GAP
  } state_t;

  state_t        state_reg;
  logic [TW-1:0] timer_reg;
  logic [GW-1:0] gap_cnt_reg;
  logic [2:0]    sample_reg;
  logic [2:0]    last_sample_reg;
  logic [2:0]    agree_reg;
  logic          meas_start_reg;
  logic [2:0]    final_answer_reg;
  logic          final_done_reg;
  logic          busy_reg;
  logic          timeout_flag_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg        <= S_IDLE;
      timer_reg        <= '0;
      gap_cnt_reg      <= '0;
      sample_reg       <= '0;
      last_sample_reg  <= NO_SAMPLE;
      agree_reg        <= '0;
      meas_start_reg   <= 1'b0;
      final_answer_reg <= '0;
      final_done_reg   <= 1'b0;
      busy_reg         <= 1'b0;
      timeout_flag_reg <= 1'b0;
    end else begin
      // Pulse outputs default low; each is raised for exactly one cycle.
      meas_start_reg   <= 1'b0;
      final_done_reg   <= 1'b0;
      timeout_flag_reg <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (enable) begin
            state_reg      <= S_START;
            meas_start_reg <= 1'b1;
            busy_reg       <= 1'b1;
          end
        end

        S_START: begin
          timer_reg <= '0;
          state_reg <= S_WAIT;
        end

        S_WAIT: begin
          // A detector answer beats a timeout landing in the same cycle.
          if (measDone) begin
            sample_reg <= (measAnswer > 3'd4) ? 3'd5 : measAnswer;
            state_reg  <= S_EVAL;
          end else if (timer_reg == TIMER_LAST) begin
            sample_reg       <= 3'd0;
            timeout_flag_reg <= 1'b1;
            state_reg        <= S_EVAL;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end

        S_EVAL: begin
          if (sample_reg == last_sample_reg) begin
            // Report only on the step into VOTES; a saturated run stays quiet.
            if (agree_reg == VOTES_PREV) begin
              final_answer_reg <= sample_reg;
              final_done_reg   <= 1'b1;
            end
            if (agree_reg != VOTES_FULL) begin
              agree_reg <= agree_reg + 3'd1;
            end
          end else begin
            last_sample_reg <= sample_reg;
            agree_reg       <= 3'd1;
          end
          gap_cnt_reg <= '0;
          state_reg   <= S_GAP;
        end

        S_GAP: begin
          if (gap_cnt_reg == GAP_LAST) begin
            if (enable) begin
              state_reg      <= S_START;
              meas_start_reg <= 1'b1;
            end else begin
              // Leaving the session: forget the voting history.
              state_reg       <= S_IDLE;
              busy_reg        <= 1'b0;
              last_sample_reg <= NO_SAMPLE;
              agree_reg       <= '0;
            end
          end else begin
            gap_cnt_reg <= gap_cnt_reg + GW'(1);
          end
        end

        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign measStart   = meas_start_reg;
  assign finalAnswer = final_answer_reg;
  assign finalDone   = final_done_reg;
  assign busy        = busy_reg;
  assign timeoutFlag = timeout_flag_reg;

endmodule

// File: tb/tb_freq_vote_controller.sv
// Testbench for freq_vote_controller (VOTES=3, TIMEOUT=16, GAP=4).
// The bench plays the frequency detector. The reference model keeps the
// sample history as "last sample + length of the current run of equal
// samples"; a report is due exactly when the run length reaches VOTES.
module tb_freq_vote_controller;

  localparam int VOTES   = 3;
  localparam int TIMEOUT = 16;
  localparam int GAP     = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [2:0] measAnswer = 3'd0;
  logic       measDone = 1'b0;
  logic       measStart;
  logic [2:0] finalAnswer;
  logic       finalDone;
  logic       busy;
  logic       timeoutFlag;

  freq_vote_controller #(
    .VOTES  (VOTES),
    .TIMEOUT(TIMEOUT),
    .GAP    (GAP)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .measAnswer (measAnswer),
    .measDone   (measDone),
    .measStart  (measStart),
    .finalAnswer(finalAnswer),
    .finalDone  (finalDone),
    .busy       (busy),
    .timeoutFlag(timeoutFlag)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int txn = 0;

  // Reference model state
  int held = 0;        // value finalAnswer must show
  int last_s = -1;     // last sample of this session, -1 = none
  int run_len = 0;     // length of the current run of equal samples
  int exp_start = -1;  // cycle the next measStart is due in, -1 = unknown

  task automatic check_value(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    last_s  = -1;
    run_len = 0;
  endtask

  task automatic model_sample(input int samp, output bit fd);
    if (samp == last_s) run_len++;
    else begin
      last_s  = samp;
      run_len = 1;
    end
    fd = (run_len == VOTES);
  endtask

  function automatic int rand_k();
    return int'($urandom_range(1, TIMEOUT));
  endfunction

  // Waits (bounded) for measStart, throwing stray measDone pulses at the
  // controller while it is not waiting for one.
  task automatic wait_start(output bit found);
    found = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clock);
      measDone = 1'b0;
      if (measStart) begin
        found = 1'b1;
        break;
      end
      check_value("idle_pulses", {timeoutFlag, finalDone}, 0);
      if ($urandom_range(0, 3) == 0) begin
        measDone   = 1'b1;
        measAnswer = 3'($urandom_range(0, 7));
      end
    end
    if (!found) check_value("start_seen", 0, 1);
    else if (exp_start >= 0) check_value("start_cycle", cyc, exp_start);
  endtask

  // One measurement. k = cycle after measStart at which measDone is given
  // (1..TIMEOUT), or 0 for no answer. mode 0 = plain, 1 = drop enable in
  // WAIT and follow the controller back to idle, 2 = reset in the EVAL cycle.
  task automatic run_meas(input int k, input int ans, input int mode);
    bit found, to, fd;
    int s, a, samp;
    wait_start(found);
    if (!found) return;
    s = cyc;
    check_value("busy_start", busy, 1);
    to = (k == 0);
    // Cycle s+TIMEOUT is the last WAIT cycle, where the timer reads TIMEOUT-1.
    a = to ? s + TIMEOUT : s + k;
    for (int j = 1; j <= a - s; j++) begin
      @(negedge clock);
      check_value("wait_pulses", {measStart, timeoutFlag, finalDone}, 0);
      check_value("busy_wait", busy, 1);
      check_value("held_answer", finalAnswer, held);
      if (mode == 1 && j == 1) enable = 1'b0;
      if (!to && j == a - s) begin
        measDone   = 1'b1;
        measAnswer = 3'(ans);
      end
    end
    @(negedge clock);  // evaluation cycle a+1
    measDone   = 1'b0;
    measAnswer = 3'($urandom_range(0, 7));
    samp = to ? 0 : ((ans > 5) ? 5 : ans);
    check_value("timeoutFlag", timeoutFlag, to);
    if (mode == 2) begin
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check_value("reset_outputs", {measStart, finalAnswer, finalDone, busy, timeoutFlag}, 0);
      model_clear();
      held = 0;
      exp_start = cyc + 1;
      $display("txn %0d start@%0d k=%0d ans=%0d sample=%0d reset in evaluation cycle",
               txn, s, k, ans, samp);
      txn++;
      return;
    end
    model_sample(samp, fd);
    @(negedge clock);  // cycle a+2
    check_value("finalDone", finalDone, fd);
    if (fd) held = samp;
    check_value("finalAnswer", finalAnswer, held);
    $display("txn %0d start@%0d k=%0d ans=%0d sample=%0d timeout=%0b finalDone=%0b finalAnswer=%0d mode=%0d",
             txn, s, k, ans, samp, to, finalDone, finalAnswer, mode);
    txn++;
    if (mode == 1) begin
      for (int c = a + 3; c <= a + GAP + 1; c++) begin
        @(negedge clock);
        check_value("gap_busy", busy, 1);
        check_value("gap_no_start", measStart, 0);
      end
      @(negedge clock);  // cycle a+GAP+2: idle
      check_value("idle_busy", busy, 0);
      check_value("idle_no_start", measStart, 0);
      model_clear();
      repeat (3) begin
        @(negedge clock);
        check_value("idle_busy", busy, 0);
        check_value("idle_no_start", measStart, 0);
      end
      enable = 1'b1;
      exp_start = cyc + 1;
    end else begin
      exp_start = a + GAP + 2;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int prev, k, ans, mode;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_value("reset_outputs", {measStart, finalAnswer, finalDone, busy, timeoutFlag}, 0);
    reset  = 1'b0;
    enable = 1'b1;
    exp_start = cyc + 1;

    // Stable run, then saturated repeats stay quiet
    repeat (3) run_meas(rand_k(), 2, 0);
    repeat (2) run_meas(rand_k(), 2, 0);
    // Broken run
    run_meas(rand_k(), 1, 0);
    run_meas(rand_k(), 1, 0);
    repeat (3) run_meas(rand_k(), 3, 0);
    // Three timeouts report class 0
    repeat (3) run_meas(0, 0, 0);
    // Answer in the timeout cycle, then invalid classes folding to 5
    run_meas(TIMEOUT, 1, 0);
    run_meas(rand_k(), 6, 0);
    run_meas(rand_k(), 7, 0);
    run_meas(rand_k(), 5, 0);
    // Enable drop clears history; two 4s afterwards do not report
    run_meas(rand_k(), 4, 0);
    run_meas(rand_k(), 4, 1);
    run_meas(rand_k(), 4, 0);
    run_meas(rand_k(), 4, 0);
    // Third agreeing 4 is cut off by reset in its evaluation cycle
    run_meas(rand_k(), 4, 2);

    prev = 0;
    for (int t = 0; t < 150; t++) begin
      k    = ($urandom_range(0, 3) == 0) ? 0 : rand_k();
      ans  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : prev;
      mode = ($urandom_range(0, 19) == 0) ? 1 : (($urandom_range(0, 29) == 0) ? 2 : 0);
      run_meas(k, ans, mode);
      prev = ans;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
